alu_seq_exec: RTL and testbench
===============================

Name: alu_seq_exec

Overview:
Parametrised multi-cycle execution unit that succeeds the combinational operation decode. It consumes the 4-bit operation code produced by the ALU control decode, together with two operands. Single-cycle ops (add, sub, move, swap, OR, AND, pass-B) complete in one cycle; unsigned multiply and divide run iteratively. Valid/ready handshakes on input and output let the datapath stall cleanly.

Parameters:
WIDTH, 16, operand width in bits (>=4); multiply/divide take WIDTH iteration cycles
CNTW, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept request
op  input  4  operation code: 0000 nop, 0001 add, 0010 sub, 0011 mult, 0100 div, 0101 move, 0110 swap, 0111 OR, 1000 AND, 1001 pass-B
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
res_lo  output  WIDTH  primary result / product low / quotient
res_hi  output  WIDTH  product high / remainder / swap second word
flag_zero  output  1  res_lo == 0
flag_carry  output  1  add: carry out; sub: borrow (a < b unsigned)
flag_ovf  output  1  signed overflow for add/sub; 0 otherwise
flag_div0  output  1  divide by zero
flag_ill  output  1  unknown opcode (1010-1111)

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous and active-high.
- States: IDLE, MUL, DIV, DONE.
- Reset: state=IDLE, counter=0. out_valid, res_lo, res_hi and all flags are 0. in_ready=0 while rst is high and 1 in the first cycle after release.
- in_ready = (state==IDLE) && !rst. A request is accepted on the edge where in_valid && in_ready; a, b and op are latched then.
- IDLE, accept, single-cycle op: compute the result, go to DONE. out_valid is high on the cycle after acceptance (latency 1).
- Single-cycle results:
  - nop: res_lo=0, res_hi=0.
  - add: res_lo=a+b.
  - sub: res_lo=a-b.
  - move: res_lo=a.
  - swap: res_lo=b, res_hi=a.
  - OR: res_lo=a|b.
  - AND: res_lo=a&b.
  - pass-B: res_lo=b.
  - res_hi=0 for every op except swap, mult and div.
- IDLE, accept, mult: go to MUL with counter=0. Shift-add over one multiplier bit per cycle, for WIDTH cycles. The 2*WIDTH unsigned product goes to {res_hi,res_lo}. Then go to DONE, so out_valid rises WIDTH+1 cycles after acceptance.
- IDLE, accept, div with b!=0: go to DIV. Restoring division, one quotient bit per cycle, WIDTH cycles. res_lo=quotient, res_hi=remainder, then DONE. Latency is WIDTH+1.
- div with b==0: no iteration; go directly to DONE with latency 1. res_lo=all ones, res_hi=a, flag_div0=1.
- Unknown opcode: latency 1; res_lo=0, res_hi=0, flag_ill=1.
- flag_zero is computed on final res_lo for every op.
- flag_carry and flag_ovf are defined only for add/sub and are 0 for all other ops.
- DONE: out_valid=1. Outputs hold stable until out_ready is sampled high; on that edge go to IDLE and out_valid drops.
  - A new request cannot be accepted in the same cycle as the result handoff; earliest acceptance is the following cycle (in_ready high in IDLE).
- in_valid during MUL/DIV/DONE is ignored (in_ready=0). Changes on a/b/op after acceptance do not affect the in-flight operation.
- Reset in any state aborts the operation and returns to reset values on the next edge; the partial result is discarded.
- Counter saturates at WIDTH-1 and terminates the iteration. No wrap-around is permitted.
- All arithmetic is unsigned except flag_ovf:
  - add overflow: a and b share a sign bit and the result sign differs.
  - sub overflow: a and b differ in sign and the result sign differs from a.

Test Plan:
- Add, WIDTH=16: a=0xFFFF, b=0x0001, op=0001 -> out_valid 1 cycle later; res_lo=0x0000, flag_carry=1, flag_zero=1, flag_ovf=0.
- Sub: a=0x8000, b=0x0001, op=0010 -> res_lo=0x7FFF, flag_ovf=1, flag_carry=0. Then a=0x0003, b=0x0005 -> res_lo=0xFFFE, flag_carry=1.
- Mult: a=0x1234, b=0x0010, op=0011 -> out_valid exactly 17 cycles after accept; res_lo=0x2340, res_hi=0x0001; in_ready=0 throughout.
- Div: a=100, b=7, op=0100 -> after 17 cycles res_lo=0x000E, res_hi=0x0002. Div by zero, a=0x00AB, b=0 -> 1 cycle; res_lo=0xFFFF, res_hi=0x00AB, flag_div0=1.
- Backpressure and swap: swap a=0x1111, b=0x2222 with out_ready held low 5 cycles -> res_lo=0x2222, res_hi=0x1111 stay stable with out_valid=1. in_valid pulses are ignored; acceptance resumes the cycle after handoff.
- Reset mid-mult: assert rst at iteration 8 -> the next cycle shows all outputs 0 and no out_valid. The first cycle after release shows in_ready=1; a fresh add completes correctly.

Source files
------------

// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - multi-cycle ALU execution unit with valid/ready handshakes
//
// Purpose: executes the 4-bit operation code from the ALU control decode.
// Single-cycle ops finish with latency 1. Unsigned multiply (shift-add) and
// unsigned divide (restoring) iterate for WIDTH cycles each.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   request handshake; op/a/b are captured on acceptance
//   op, a, b            operation code and operands
//   out_valid/out_ready result handshake; results hold until taken
//   res_lo, res_hi      result words (low/quotient, high/remainder/swap)
//   flag_*              zero, carry/borrow, signed overflow, div-by-zero, illegal op
module alu_seq_exec #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_div0,
    output logic             flag_ill
);

    localparam int CNTW = $clog2(WIDTH) + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MULT = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_MOVE = 4'b0101;
    localparam logic [3:0] OP_SWAP = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_PASB = 4'b1001;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state_q;
    logic [CNTW-1:0]  cnt_q;
    logic [WIDTH-1:0] opnd_q;     // multiplicand (mult) or divisor (div)
    logic [WIDTH-1:0] work_hi_q;  // partial product high / running remainder
    logic [WIDTH-1:0] work_lo_q;  // multiplier being shifted out / dividend -> quotient

    logic             out_valid_q;
    logic [WIDTH-1:0] res_lo_q;
    logic [WIDTH-1:0] res_hi_q;
    logic             flag_zero_q;
    logic             flag_carry_q;
    logic             flag_ovf_q;
    logic             flag_div0_q;
    logic             flag_ill_q;

    // Single-cycle result, computed straight from the inputs on the accept edge
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH-1:0] sc_lo_d;
    logic [WIDTH-1:0] sc_hi_d;
    logic             sc_carry_d;
    logic             sc_ovf_d;
    logic             sc_div0_d;
    logic             sc_ill_d;

    // One iteration step of the multiplier and divider
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_d;
    logic [WIDTH-1:0] mul_lo_d;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] div_rem_d;
    logic [WIDTH-1:0] div_quo_d;

    logic             cnt_last;
    logic [CNTW-1:0]  cnt_d;

    assign in_ready = (state_q == S_IDLE) && !rst;

    always_comb begin
        add_sum    = {1'b0, a} + {1'b0, b};
        sub_diff   = {1'b0, a} - {1'b0, b};
        sc_lo_d    = '0;
        sc_hi_d    = '0;
        sc_carry_d = 1'b0;
        sc_ovf_d   = 1'b0;
        sc_div0_d  = 1'b0;
        sc_ill_d   = 1'b0;
        case (op)
            OP_NOP: ;
            OP_ADD: begin
                sc_lo_d    = add_sum[WIDTH-1:0];
                sc_carry_d = add_sum[WIDTH];
                sc_ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo_d    = sub_diff[WIDTH-1:0];
                sc_carry_d = sub_diff[WIDTH];   // borrow: a < b unsigned
                sc_ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MULT: ;                          // iterative path, not used here
            OP_DIV: begin                       // only reaches DONE directly when b == 0
                sc_lo_d   = '1;
                sc_hi_d   = a;
                sc_div0_d = 1'b1;
            end
            OP_MOVE: sc_lo_d = a;
            OP_SWAP: begin
                sc_lo_d = b;
                sc_hi_d = a;
            end
            OP_OR:   sc_lo_d = a | b;
            OP_AND:  sc_lo_d = a & b;
            OP_PASB: sc_lo_d = b;
            default: sc_ill_d = 1'b1;
        endcase
    end

    always_comb begin
        // Shift-add: add multiplicand when the current multiplier LSB is set,
        // then shift the {carry, high, low} triple right by one.
        mul_sum  = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi_d = mul_sum[WIDTH:1];
        mul_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};

        // Restoring division: bring the next dividend bit into the remainder,
        // trial-subtract the divisor and keep the difference if no borrow.
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!div_diff[WIDTH]) begin
            div_rem_d = div_diff[WIDTH-1:0];
            div_quo_d = {work_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_d = div_shift[WIDTH-1:0];
            div_quo_d = {work_lo_q[WIDTH-2:0], 1'b0};
        end

        // Counter stops at WIDTH-1; that value marks the final iteration.
        cnt_last = (cnt_q == CNT_LAST);
        cnt_d    = cnt_last ? cnt_q : cnt_q + CNTW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            opnd_q       <= '0;
            work_hi_q    <= '0;
            work_lo_q    <= '0;
            out_valid_q  <= 1'b0;
            res_lo_q     <= '0;
            res_hi_q     <= '0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
            flag_ovf_q   <= 1'b0;
            flag_div0_q  <= 1'b0;
            flag_ill_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MULT) begin
                            state_q   <= S_MUL;
                            cnt_q     <= '0;
                            opnd_q    <= a;
                            work_hi_q <= '0;
                            work_lo_q <= b;
                        end else if (op == OP_DIV && b != '0) begin
                            state_q   <= S_DIV;
                            cnt_q     <= '0;
                            opnd_q    <= b;
                            work_hi_q <= '0;
                            work_lo_q <= a;
                        end else begin
                            state_q      <= S_DONE;
                            out_valid_q  <= 1'b1;
                            res_lo_q     <= sc_lo_d;
                            res_hi_q     <= sc_hi_d;
                            flag_zero_q  <= (sc_lo_d == '0);
                            flag_carry_q <= sc_carry_d;
                            flag_ovf_q   <= sc_ovf_d;
                            flag_div0_q  <= sc_div0_d;
                            flag_ill_q   <= sc_ill_d;
                        end
                    end
                end
                S_MUL: begin
                    work_hi_q <= mul_hi_d;
                    work_lo_q <= mul_lo_d;
                    cnt_q     <= cnt_d;
                    if (cnt_last) begin
                        state_q      <= S_DONE;
                        out_valid_q  <= 1'b1;
                        res_lo_q     <= mul_lo_d;
                        res_hi_q     <= mul_hi_d;
                        flag_zero_q  <= (mul_lo_d == '0);
                        flag_carry_q <= 1'b0;
                        flag_ovf_q   <= 1'b0;
                        flag_div0_q  <= 1'b0;
                        flag_ill_q   <= 1'b0;
                    end
                end
                S_DIV: begin
                    work_hi_q <= div_rem_d;
                    work_lo_q <= div_quo_d;
                    cnt_q     <= cnt_d;
                    if (cnt_last) begin
                        state_q      <= S_DONE;
                        out_valid_q  <= 1'b1;
                        res_lo_q     <= div_quo_d;
                        res_hi_q     <= div_rem_d;
                        flag_zero_q  <= (div_quo_d == '0);
                        flag_carry_q <= 1'b0;
                        flag_ovf_q   <= 1'b0;
                        flag_div0_q  <= 1'b0;
                        flag_ill_q   <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign res_lo     = res_lo_q;
    assign res_hi     = res_hi_q;
    assign flag_zero  = flag_zero_q;
    assign flag_carry = flag_carry_q;
    assign flag_ovf   = flag_ovf_q;
    assign flag_div0  = flag_div0_q;
    assign flag_ill   = flag_ill_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - directed self-checking bench for alu_seq_exec
module tb_alu_seq_exec;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] res_lo;
    logic [15:0] res_hi;
    logic        flag_zero;
    logic        flag_carry;
    logic        flag_ovf;
    logic        flag_div0;
    logic        flag_ill;
    logic [4:0]  flags;

    int checks   = 0;
    int failures = 0;

    alu_seq_exec #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .res_lo     (res_lo),
        .res_hi     (res_hi),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf),
        .flag_div0  (flag_div0),
        .flag_ill   (flag_ill)
    );

    // {zero, carry, ovf, div0, ill}
    assign flags = {flag_zero, flag_carry, flag_ovf, flag_div0, flag_ill};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble inputs while it is in flight, check latency,
    // results and flags, then hand the result off.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] av,
                          input logic [15:0] bv, input int lat, input logic [15:0] elo,
                          input logic [15:0] ehi, input logic [4:0] eflg);
        check({tag, "_rdy_before"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op = o;
        a = av;
        b = bv;
        step();
        in_valid = 1'b0;
        a = ~av;
        b = ~bv;
        op = 4'h1;
        for (int i = 1; i < lat; i++) begin
            check({tag, "_busy_valid"}, {31'b0, out_valid}, 32'd0);
            check({tag, "_busy_rdy"}, {31'b0, in_ready}, 32'd0);
            in_valid = i[0];
            step();
        end
        in_valid = 1'b0;
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_lo"}, {16'b0, res_lo}, {16'b0, elo});
        check({tag, "_hi"}, {16'b0, res_hi}, {16'b0, ehi});
        check({tag, "_flags"}, {27'b0, flags}, {27'b0, eflg});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_after"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 4'h0;
        a = 16'h0;
        b = 16'h0;
        step();
        step();
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_res_lo", {16'b0, res_lo}, 32'd0);
        check("rst_res_hi", {16'b0, res_hi}, 32'd0);
        check("rst_flags", {27'b0, flags}, 32'd0);
        rst = 1'b0;
        #1;
        check("release_in_ready", {31'b0, in_ready}, 32'd1);

        run_op("add_wrap",  4'b0001, 16'hFFFF, 16'h0001, 1,  16'h0000, 16'h0000, 5'b11000);
        run_op("add_ovf",   4'b0001, 16'h7FFF, 16'h0001, 1,  16'h8000, 16'h0000, 5'b00100);
        run_op("sub_ovf",   4'b0010, 16'h8000, 16'h0001, 1,  16'h7FFF, 16'h0000, 5'b00100);
        run_op("sub_borr",  4'b0010, 16'h0003, 16'h0005, 1,  16'hFFFE, 16'h0000, 5'b01000);
        run_op("mul",       4'b0011, 16'h1234, 16'h0010, 17, 16'h2340, 16'h0001, 5'b00000);
        run_op("mul_max",   4'b0011, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 16'hFFFE, 5'b00000);
        run_op("mul_zero",  4'b0011, 16'h0000, 16'h1234, 17, 16'h0000, 16'h0000, 5'b10000);
        run_op("div",       4'b0100, 16'd100,  16'd7,    17, 16'h000E, 16'h0002, 5'b00000);
        run_op("div_one",   4'b0100, 16'hFFFF, 16'h0001, 17, 16'hFFFF, 16'h0000, 5'b00000);
        run_op("div_small", 4'b0100, 16'h0003, 16'h0009, 17, 16'h0000, 16'h0003, 5'b10000);
        run_op("div0",      4'b0100, 16'h00AB, 16'h0000, 1,  16'hFFFF, 16'h00AB, 5'b00010);
        run_op("or",        4'b0111, 16'hF0F0, 16'h0F0F, 1,  16'hFFFF, 16'h0000, 5'b00000);
        run_op("and",       4'b1000, 16'hF0F0, 16'h0F0F, 1,  16'h0000, 16'h0000, 5'b10000);
        run_op("move",      4'b0101, 16'h00A5, 16'h1234, 1,  16'h00A5, 16'h0000, 5'b00000);
        run_op("passb",     4'b1001, 16'h1234, 16'h5A5A, 1,  16'h5A5A, 16'h0000, 5'b00000);
        run_op("nop",       4'b0000, 16'h1234, 16'h5678, 1,  16'h0000, 16'h0000, 5'b10000);
        run_op("ill",       4'b1100, 16'h1234, 16'h5678, 1,  16'h0000, 16'h0000, 5'b10001);

        // Swap under backpressure: result must hold while in_valid pulses are ignored.
        in_valid = 1'b1;
        op = 4'b0110;
        a = 16'h1111;
        b = 16'h2222;
        step();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            op = 4'b0001;
            a = 16'h0000;
            b = 16'h0000;
            check("swap_hold_valid", {31'b0, out_valid}, 32'd1);
            check("swap_hold_lo", {16'b0, res_lo}, 32'h2222);
            check("swap_hold_hi", {16'b0, res_hi}, 32'h1111);
            check("swap_hold_rdy", {31'b0, in_ready}, 32'd0);
            step();
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("swap_after_valid", {31'b0, out_valid}, 32'd0);
        check("swap_after_rdy", {31'b0, in_ready}, 32'd1);
        run_op("or_resume", 4'b0111, 16'h0100, 16'h0001, 1, 16'h0101, 16'h0000, 5'b00000);

        // Reset in the middle of a multiply.
        in_valid = 1'b1;
        op = 4'b0011;
        a = 16'h1234;
        b = 16'h0010;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        check("midmul_busy", {31'b0, out_valid}, 32'd0);
        rst = 1'b1;
        step();
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_lo", {16'b0, res_lo}, 32'd0);
        check("midrst_hi", {16'b0, res_hi}, 32'd0);
        check("midrst_flags", {27'b0, flags}, 32'd0);
        check("midrst_rdy", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_release_rdy", {31'b0, in_ready}, 32'd1);
        step();
        check("midrst_idle_valid", {31'b0, out_valid}, 32'd0);
        run_op("add_fresh", 4'b0001, 16'h0002, 16'h0003, 1, 16'h0005, 16'h0000, 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
